// File: rtl/sram_axi_arbiter_pkg.sv
// Shared encodings and helpers for the SRAM-like to AXI3 arbiter.
package sram_axi_arbiter_pkg;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_AR   = 2'd1,
        R_WAIT = 2'd2
    } r_state_e;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_AW   = 2'd1,
        W_B    = 2'd2
    } w_state_e;

    localparam logic       OWNER_INST  = 1'b0;
    localparam logic       OWNER_DATA  = 1'b1;
    localparam logic [2:0] AXSIZE_WORD = 3'd2;

    // SRAM-side size code (0 byte, 1 half, 2 word) to AXI ax*size; 3 is treated as word
    function automatic logic [2:0] size_to_axsize(input logic [1:0] size);
        case (size)
            2'd0:    return 3'd0;
            2'd1:    return 3'd1;
            default: return 3'd2;
        endcase
    endfunction

endpackage

// File: rtl/sram_axi_arbiter_axi_write_channel.sv
// axi_write_channel: single-beat AXI write sequencer. AW and W are issued together
// and retire independently; B is awaited once both address and data are accepted.
module axi_write_channel
    import sram_axi_arbiter_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic [31:0] addr_i,
    input  logic [2:0]  size_i,
    input  logic [31:0] wdata_i,
    input  logic [3:0]  wstrb_i,
    output logic [31:0] awaddr_o,
    output logic [2:0]  awsize_o,
    output logic        awvalid_o,
    input  logic        awready_i,
    output logic [31:0] wdata_o,
    output logic [3:0]  wstrb_o,
    output logic        wvalid_o,
    input  logic        wready_i,
    input  logic        bvalid_i,
    output logic        bready_o,
    output logic        idle_o,
    output logic        done_o
);

    w_state_e    state_q, state_d;
    logic        aw_pend_q, aw_pend_d;
    logic        w_pend_q, w_pend_d;
    logic [31:0] addr_q, wdata_q;
    logic [2:0]  size_q;
    logic [3:0]  wstrb_q;

    // state, pending flags and the captured store beat
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= W_IDLE;
            aw_pend_q <= 1'b0;
            w_pend_q  <= 1'b0;
            addr_q    <= '0;
            size_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
        end else begin
            state_q   <= state_d;
            aw_pend_q <= aw_pend_d;
            w_pend_q  <= w_pend_d;
            if (start_i && state_q == W_IDLE) begin
                addr_q  <= addr_i;
                size_q  <= size_i;
                wdata_q <= wdata_i;
                wstrb_q <= wstrb_i;
            end
        end
    end

    // next state: leave W_AW only when both handshakes are done, in any order
    always_comb begin
        state_d   = state_q;
        aw_pend_d = aw_pend_q;
        w_pend_d  = w_pend_q;
        case (state_q)
            W_IDLE: begin
                if (start_i) begin
                    state_d   = W_AW;
                    aw_pend_d = 1'b1;
                    w_pend_d  = 1'b1;
                end
            end
            W_AW: begin
                if (awready_i) aw_pend_d = 1'b0;
                if (wready_i)  w_pend_d  = 1'b0;
                if (!aw_pend_d && !w_pend_d) state_d = W_B;
            end
            W_B: begin
                if (bvalid_i) state_d = W_IDLE;
            end
            default: state_d = W_IDLE;
        endcase
    end

    // channel outputs
    always_comb begin
        awvalid_o = (state_q == W_AW) && aw_pend_q;
        wvalid_o  = (state_q == W_AW) && w_pend_q;
        bready_o  = (state_q == W_B);
        idle_o    = (state_q == W_IDLE);
        done_o    = (state_q == W_B) && bvalid_i;
        awaddr_o  = addr_q;
        awsize_o  = size_q;
        wdata_o   = wdata_q;
        wstrb_o   = wstrb_q;
    end

endmodule

// File: rtl/sram_axi_arbiter.sv
// sram_axi_arbiter: shares one single-beat AXI3 master between the fetch and
// mem-stage SRAM-like ports. One read (AR/R) and one write (AW/W/B) in flight.
// Build option ARB_ROUND_ROBIN_EN: inst/data-load contention alternates;
// otherwise data loads always win.
module sram_axi_arbiter
    import sram_axi_arbiter_pkg::*;
#(
    parameter logic [3:0] AXI_ID = 4'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    input  logic [3:0]  data_wstrb,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [3:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic        arvalid,
    input  logic        arready,
    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic        rvalid,
    output logic        rready,
    output logic [3:0]  awid,
    output logic [31:0] awaddr,
    output logic [3:0]  awlen,
    output logic [2:0]  awsize,
    output logic [1:0]  awburst,
    output logic        awvalid,
    input  logic        awready,
    output logic [3:0]  wid,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wlast,
    output logic        wvalid,
    input  logic        wready,
    input  logic        bvalid,
    output logic        bready
);

    r_state_e    r_state_q, r_state_d;
    logic [31:0] araddr_q, inst_rdata_q, data_rdata_q;
    logic [2:0]  arsize_q;
    logic        owner_q, inst_ok_q, data_ok_q, data_busy_q;
    logic        w_idle, w_done, store_go, load_cand, grant_inst, grant_data;
    logic        data_wins, r_hs, inst_ok_d, data_ok_d;
    logic        unused_rid;

    // single ID: responses are never reordered, so rid carries no information
    assign unused_rid = ^rid;

`ifdef ARB_ROUND_ROBIN_EN
    logic last_q;
    assign data_wins = (last_q == OWNER_INST);

    // remember which side won the most recent read grant
    always_ff @(posedge clk or posedge rst) begin
        if (rst)             last_q <= OWNER_INST;
        else if (grant_data) last_q <= OWNER_DATA;
        else if (grant_inst) last_q <= OWNER_INST;
    end
`else
    assign data_wins = 1'b1;
`endif

    // read grant: loads wait for any store in flight and for the previous data op
    always_comb begin
        load_cand  = data_req && !data_wr && w_idle && !data_busy_q;
        store_go   = data_req &&  data_wr && w_idle && !data_busy_q;
        grant_data = 1'b0;
        grant_inst = 1'b0;
        if (r_state_q == R_IDLE) begin
            if (load_cand && inst_req) begin
                grant_data = data_wins;
                grant_inst = !data_wins;
            end else begin
                grant_data = load_cand;
                grant_inst = inst_req;
            end
        end
    end

    assign r_hs      = (r_state_q == R_WAIT) && rvalid;
    assign inst_ok_d = r_hs && (owner_q == OWNER_INST);
    assign data_ok_d = w_done || (r_hs && (owner_q == OWNER_DATA));

    // read FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state_q <= R_IDLE;
        else     r_state_q <= r_state_d;
    end

    // read FSM next state
    always_comb begin
        r_state_d = r_state_q;
        case (r_state_q)
            R_IDLE:  if (grant_inst || grant_data) r_state_d = R_AR;
            R_AR:    if (arready) r_state_d = R_WAIT;
            R_WAIT:  if (rvalid)  r_state_d = R_IDLE;
            default: r_state_d = R_IDLE;
        endcase
    end

    // read FSM outputs
    always_comb begin
        arvalid = 1'b0;
        rready  = 1'b0;
        case (r_state_q)
            R_AR:    arvalid = 1'b1;
            R_WAIT:  rready  = 1'b1;
            default: ;
        endcase
    end

    // read request capture, returned data and the data-side outstanding flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            araddr_q     <= '0;
            arsize_q     <= '0;
            owner_q      <= OWNER_INST;
            inst_rdata_q <= '0;
            data_rdata_q <= '0;
            inst_ok_q    <= 1'b0;
            data_ok_q    <= 1'b0;
            data_busy_q  <= 1'b0;
        end else begin
            inst_ok_q   <= inst_ok_d;
            data_ok_q   <= data_ok_d;
            data_busy_q <= grant_data || store_go || (data_busy_q && !data_ok_d);
            if (grant_data || grant_inst) begin
                araddr_q <= grant_data ? data_addr : inst_addr;
                arsize_q <= grant_data ? size_to_axsize(data_size) : AXSIZE_WORD;
                owner_q  <= grant_data ? OWNER_DATA : OWNER_INST;
            end
            if (inst_ok_d) inst_rdata_q <= rdata;
            if (r_hs && owner_q == OWNER_DATA) data_rdata_q <= rdata;
        end
    end

    axi_write_channel u_wr (
        .clk       (clk),
        .rst       (rst),
        .start_i   (store_go),
        .addr_i    (data_addr),
        .size_i    (size_to_axsize(data_size)),
        .wdata_i   (data_wdata),
        .wstrb_i   (data_wstrb),
        .awaddr_o  (awaddr),
        .awsize_o  (awsize),
        .awvalid_o (awvalid),
        .awready_i (awready),
        .wdata_o   (wdata),
        .wstrb_o   (wstrb),
        .wvalid_o  (wvalid),
        .wready_i  (wready),
        .bvalid_i  (bvalid),
        .bready_o  (bready),
        .idle_o    (w_idle),
        .done_o    (w_done)
    );

    assign inst_addr_ok = grant_inst;
    assign data_addr_ok = grant_data || store_go;
    assign inst_data_ok = inst_ok_q;
    assign data_data_ok = data_ok_q;
    assign inst_rdata   = inst_rdata_q;
    assign data_rdata   = data_rdata_q;
    assign araddr       = araddr_q;
    assign arsize       = arsize_q;
    assign arid         = AXI_ID;
    assign arlen        = 4'd0;
    assign arburst      = 2'b01;
    assign awid         = AXI_ID;
    assign awlen        = 4'd0;
    assign awburst      = 2'b01;
    assign wid          = AXI_ID;
    assign wlast        = 1'b1;

endmodule

// File: tb/tb_sram_axi_arbiter.sv
// Bench for sram_axi_arbiter: directed scenarios followed by a randomized run
// against a transaction-level requester/slave model.
module tb_sram_axi_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_req, inst_addr_ok, inst_data_ok;
    logic [31:0] inst_addr, inst_rdata;
    logic        data_req, data_wr, data_addr_ok, data_data_ok;
    logic [1:0]  data_size;
    logic [31:0] data_addr, data_wdata, data_rdata;
    logic [3:0]  data_wstrb;
    logic [3:0]  arid, arlen, rid, awid, awlen, wid;
    logic [31:0] araddr, rdata, awaddr, wdata;
    logic [2:0]  arsize, awsize;
    logic [1:0]  arburst, awburst;
    logic        arvalid, arready, rvalid, rready;
    logic        awvalid, awready, wvalid, wready, wlast, bvalid, bready;
    logic [3:0]  wstrb;

    always #5 clk = ~clk;

    sram_axi_arbiter dut (
        .clk(clk), .rst(rst),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
        .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_addr(data_addr), .data_wdata(data_wdata), .data_wstrb(data_wstrb),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bvalid(bvalid), .bready(bready)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5A1234;
    endfunction

    function automatic logic [2:0] exp_axsize(input logic [1:0] s);
        return (s == 2'd0) ? 3'd0 : (s == 2'd1) ? 3'd1 : 3'd2;
    endfunction

    task automatic idle_inputs();
        inst_req = 0; inst_addr = 0;
        data_req = 0; data_wr = 0; data_size = 0; data_addr = 0; data_wdata = 0; data_wstrb = 0;
        arready = 0; rid = 4'd0; rdata = 0; rvalid = 0;
        awready = 0; wready = 0; bvalid = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // reset released one time unit after an edge
    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // random-phase model state
    typedef struct packed {
        logic [31:0] addr;
        logic [2:0]  size;
        logic        own_data;
    } ar_t;

    ar_t         ar_q[$];
    logic [31:0] exp_inst[$];
    logic        inst_take, data_take, data_out, cur_wr;
    logic [31:0] cur_addr, cur_wdata;
    logic [1:0]  cur_size;
    logic [3:0]  cur_wstrb;
    logic        rd_busy, rd_own, rok_due, rok_own, aw_got, w_got, b_armed, b_due, quiesce;
    logic [31:0] rd_val;
    int          rd_wait, b_wait;

    initial begin
        rst = 1'b1;
        idle_inputs();
        #3;
        chk("rst_inst_addr_ok", inst_addr_ok, 0);
        chk("rst_data_addr_ok", data_addr_ok, 0);
        chk("rst_inst_data_ok", inst_data_ok, 0);
        chk("rst_data_data_ok", data_data_ok, 0);
        chk("rst_arvalid", arvalid, 0);
        chk("rst_rready", rready, 0);
        chk("rst_awvalid", awvalid, 0);
        chk("rst_wvalid", wvalid, 0);
        chk("rst_bready", bready, 0);
        chk("rst_inst_rdata", inst_rdata, 0);
        chk("rst_data_rdata", data_rdata, 0);

        // 1) single fetch
        do_reset();
        inst_req = 1; inst_addr = 32'hBFC00000; arready = 1; #1;
        chk("t1_addr_ok", inst_addr_ok, 1);
        chk("t1_arvalid_t0", arvalid, 0);
        step(); inst_req = 0; #1;
        chk("t1_arvalid", arvalid, 1);
        chk("t1_araddr", araddr, 32'hBFC00000);
        chk("t1_arsize", arsize, 2);
        step(); arready = 0; #1;
        chk("t1_rready", rready, 1);
        chk("t1_arvalid_off", arvalid, 0);
        step(); rvalid = 1; rdata = 32'h3C1D0001; #1;
        chk("t1_ok_early", inst_data_ok, 0);
        step(); rvalid = 0; rdata = 0; #1;
        chk("t1_data_ok", inst_data_ok, 1);
        chk("t1_rdata", inst_rdata, 32'h3C1D0001);
        step(); #1;
        chk("t1_ok_pulse", inst_data_ok, 0);

        // 2) inst and load contend
        do_reset();
        inst_req = 1; inst_addr = 32'hBFC00010;
        data_req = 1; data_wr = 0; data_size = 2; data_addr = 32'h80001000; arready = 1; #1;
        chk("t2_data_first", data_addr_ok, 1);
        chk("t2_inst_waits", inst_addr_ok, 0);
        step(); data_req = 0; #1;
        chk("t2_araddr", araddr, 32'h80001000);
        chk("t2_inst_blocked_ar", inst_addr_ok, 0);
        step(); rvalid = 1; rdata = 32'h11112222; #1;
        chk("t2_inst_blocked_r", inst_addr_ok, 0);
        step(); rvalid = 0; data_req = 1; data_addr = 32'h80001004; #1;
        chk("t2_data_ok", data_data_ok, 1);
        chk("t2_data_rdata", data_rdata, 32'h11112222);
`ifdef ARB_ROUND_ROBIN_EN
        chk("t2_rr_inst", inst_addr_ok, 1);
        chk("t2_rr_data", data_addr_ok, 0);
        step(); data_req = 0; inst_req = 0; #1;
        chk("t2_rr_araddr", araddr, 32'hBFC00010);
`else
        chk("t2_fp_data", data_addr_ok, 1);
        chk("t2_fp_inst", inst_addr_ok, 0);
        step(); data_req = 0; #1;
        chk("t2_araddr2", araddr, 32'h80001004);
        step(); rvalid = 1; rdata = 32'h33334444; #1;
        step(); rvalid = 0; #1;
        chk("t2_data_ok2", data_data_ok, 1);
        chk("t2_inst_after", inst_addr_ok, 1);
`endif

        // 3) byte store, AW accepted 3 cycles before W
        do_reset();
        data_req = 1; data_wr = 1; data_size = 0; data_addr = 32'h80000003;
        data_wdata = 32'hAB000000; data_wstrb = 4'b1000; #1;
        chk("t3_addr_ok", data_addr_ok, 1);
        step(); data_req = 0; awready = 1; #1;
        chk("t3_awvalid", awvalid, 1);
        chk("t3_wvalid", wvalid, 1);
        chk("t3_awaddr", awaddr, 32'h80000003);
        chk("t3_awsize", awsize, 0);
        chk("t3_wstrb", wstrb, 4'b1000);
        chk("t3_wdata", wdata, 32'hAB000000);
        chk("t3_wlast", wlast, 1);
        step(); awready = 0; #1;
        chk("t3_aw_dropped", awvalid, 0);
        chk("t3_w_held1", wvalid, 1);
        step(); #1;
        chk("t3_w_held2", wvalid, 1);
        step(); wready = 1; #1;
        chk("t3_w_held3", wvalid, 1);
        chk("t3_bready_early", bready, 0);
        step(); wready = 0; bvalid = 1; #1;
        chk("t3_w_dropped", wvalid, 0);
        chk("t3_bready", bready, 1);
        chk("t3_ok_early", data_data_ok, 0);
        step(); bvalid = 0; #1;
        chk("t3_data_ok", data_data_ok, 1);
        step(); #1;
        chk("t3_ok_pulse", data_data_ok, 0);

        // 4) load blocked behind store in W_B while fetch proceeds
        do_reset();
        data_req = 1; data_wr = 1; data_size = 2; data_addr = 32'h80000010;
        data_wdata = 32'h01020304; data_wstrb = 4'hF; #1;
        chk("t4_st_ok", data_addr_ok, 1);
        step(); data_req = 0; awready = 1; wready = 1; #1;
        step(); awready = 0; wready = 0;
        data_req = 1; data_wr = 0; data_addr = 32'h80002000;
        inst_req = 1; inst_addr = 32'h80003000; arready = 1; #1;
        chk("t4_bready", bready, 1);
        chk("t4_ld_blocked1", data_addr_ok, 0);
        chk("t4_fetch_go", inst_addr_ok, 1);
        step(); inst_req = 0; #1;
        chk("t4_fetch_araddr", araddr, 32'h80003000);
        chk("t4_ld_blocked2", data_addr_ok, 0);
        step(); rvalid = 1; rdata = 32'hCAFEF00D; #1;
        chk("t4_ld_blocked3", data_addr_ok, 0);
        step(); rvalid = 0; bvalid = 1; #1;
        chk("t4_fetch_ok", inst_data_ok, 1);
        chk("t4_fetch_rdata", inst_rdata, 32'hCAFEF00D);
        chk("t4_ld_blocked4", data_addr_ok, 0);
        step(); bvalid = 0; #1;
        chk("t4_st_done", data_data_ok, 1);
        chk("t4_ld_go", data_addr_ok, 1);
        step(); data_req = 0; #1;
        chk("t4_ld_arvalid", arvalid, 1);
        chk("t4_ld_araddr", araddr, 32'h80002000);

        // 5) reset while waiting for R
        do_reset();
        inst_req = 1; inst_addr = 32'hBFC00100; arready = 1; #1;
        step(); inst_req = 0; #1;
        step(); #1;
        chk("t5_in_wait", rready, 1);
        rst = 1; #1;
        chk("t5_async_rready", rready, 0);
        step(); #1;
        chk("t5_arvalid", arvalid, 0);
        chk("t5_rready", rready, 0);
        chk("t5_inst_ok", inst_data_ok, 0);
        rst = 0;
        step(); inst_req = 1; inst_addr = 32'hBFC00200; #1;
        chk("t5_new_addr_ok", inst_addr_ok, 1);
        step(); inst_req = 0; #1;
        chk("t5_new_araddr", araddr, 32'hBFC00200);
        step(); rvalid = 1; rdata = 32'h12345678; #1;
        step(); rvalid = 0; #1;
        chk("t5_new_ok", inst_data_ok, 1);
        chk("t5_new_rdata", inst_rdata, 32'h12345678);

        // 6) AR stalled for 10 cycles
        do_reset();
        inst_req = 1; inst_addr = 32'hBFC00300; #1;
        chk("t6_addr_ok", inst_addr_ok, 1);
        step(); inst_addr = 32'hBFC00304; #1;
        for (int i = 0; i < 10; i++) begin
            chk("t6_arvalid", arvalid, 1);
            chk("t6_araddr", araddr, 32'hBFC00300);
            chk("t6_arsize", arsize, 2);
            chk("t6_no_2nd_ok", inst_addr_ok, 0);
            step(); #1;
        end
        arready = 1;
        step(); #1;
        chk("t6_released", rready, 1);

        // randomized run
        do_reset();
        ar_q.delete(); exp_inst.delete();
        inst_take = 0; data_take = 0; data_out = 0; cur_wr = 0;
        cur_addr = 0; cur_wdata = 0; cur_size = 0; cur_wstrb = 0;
        rd_busy = 0; rd_own = 0; rok_due = 0; rok_own = 0; rd_val = 0; rd_wait = 0;
        aw_got = 0; w_got = 0; b_armed = 0; b_due = 0; b_wait = 0; quiesce = 0;
        for (int c = 0; c < 4000; c++) begin
            step();
            quiesce = (c >= 3940);
            // requesters
            if (!inst_req || inst_take) begin
                inst_req  = !quiesce && ($urandom_range(0, 2) != 0);
                inst_addr = $urandom() & 32'hFFFFFFFC;
            end
            if (!data_req || data_take) begin
                data_req   = !quiesce && ($urandom_range(0, 1) != 0);
                data_wr    = $urandom_range(0, 1);
                data_size  = 2'($urandom_range(0, 2));
                data_addr  = $urandom();
                if (data_size == 2'd1) data_addr[0] = 1'b0;
                if (data_size == 2'd2) data_addr[1:0] = 2'b00;
                data_wdata = $urandom();
                data_wstrb = 4'($urandom_range(1, 15));
            end
            // slave
            arready = ($urandom_range(0, 2) != 0);
            if (rd_busy && rd_wait == 0) begin
                rvalid = 1; rdata = rd_val;
            end else begin
                rvalid = 0; rdata = $urandom();
                if (rd_busy) rd_wait--;
            end
            awready = $urandom_range(0, 1);
            wready  = $urandom_range(0, 1);
            if (b_armed && b_wait == 0) bvalid = 1;
            else begin
                bvalid = 0;
                if (b_armed) b_wait--;
            end
            #1;
            // responses due from the previous edge
            chk("inst_data_ok", inst_data_ok, rok_due && !rok_own);
            chk("data_data_ok", data_data_ok, (rok_due && rok_own) || b_due);
            if (inst_data_ok && exp_inst.size() > 0)
                chk("inst_rdata", inst_rdata, mem_word(exp_inst.pop_front()));
            if (data_data_ok && data_out) begin
                if (!cur_wr) chk("load_rdata", data_rdata, mem_word(cur_addr));
                data_out = 0;
            end
            // grants
            inst_take = inst_addr_ok;
            data_take = data_addr_ok;
            if (inst_addr_ok) begin
`ifndef ARB_ROUND_ROBIN_EN
                chk("fixed_prio", data_req && !data_wr && !data_out, 0);
`endif
                if (data_addr_ok) chk("one_read_grant", data_wr, 1);
                exp_inst.push_back(inst_addr);
                ar_q.push_back('{addr: inst_addr, size: 3'd2, own_data: 1'b0});
            end
            if (data_addr_ok) begin
                chk("data_one_outstanding", data_out, 0);
                data_out  = 1;
                cur_wr    = data_wr;
                cur_addr  = data_addr;
                cur_size  = data_size;
                cur_wdata = data_wdata;
                cur_wstrb = data_wstrb;
                if (!data_wr)
                    ar_q.push_back('{addr: data_addr, size: exp_axsize(data_size), own_data: 1'b1});
            end
            // AXI read side
            if (arvalid && arready) begin
                if (ar_q.size() == 0) chk("ar_spurious", arvalid, 0);
                else begin
                    ar_t e;
                    e = ar_q.pop_front();
                    chk("araddr", araddr, e.addr);
                    chk("arsize", arsize, e.size);
                    rd_busy = 1; rd_own = e.own_data; rd_val = mem_word(e.addr);
                    rd_wait = $urandom_range(0, 3);
                end
            end
            rok_due = rvalid && rready;
            rok_own = rd_own;
            if (rvalid && rready) rd_busy = 0;
            // AXI write side
            if (awvalid) begin
                chk("aw_once", aw_got, 0);
                chk("aw_for_store", data_out && cur_wr, 1);
                if (awready) begin
                    chk("awaddr", awaddr, cur_addr);
                    chk("awsize", awsize, exp_axsize(cur_size));
                    aw_got = 1;
                end
            end
            if (wvalid) begin
                chk("w_once", w_got, 0);
                if (wready) begin
                    chk("wdata", wdata, cur_wdata);
                    chk("wstrb", wstrb, cur_wstrb);
                    chk("wlast", wlast, 1);
                    w_got = 1;
                end
            end
            if (aw_got && w_got && !b_armed) begin
                b_armed = 1;
                b_wait  = $urandom_range(0, 3);
            end
            b_due = bvalid && bready;
            if (bvalid && bready) begin
                aw_got = 0; w_got = 0; b_armed = 0;
            end
        end
        chk("drain_inst", exp_inst.size(), 0);
        chk("drain_data", data_out, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
